// File: rtl/aes_key_sched_cntl.sv
// Purpose : AES-128 key expansion controller, one round per cycle, with a registered round-key read port.
// Latency : keys_ready rises 10 edges after the key_load edge; rk_out follows rk_idx by 1 cycle.
// Backpres: none; key_load restarts expansion from any state, and keys_ready gates the cipher.
//
// Ports:
//   ACLK, ARESETN   clock and asynchronous active-low reset
//   key_in/key_load cipher key and a one-cycle capture/start pulse
//   sbox_in/sbox_out RotWord(w3) to the external S-box and SubWord result back (same cycle)
//   rk_idx/rk_out   round-key index 0..10 and the registered round key (0 for 11..15)
//   busy/keys_ready expansion running / all 11 round keys valid for the current key
module aes_key_sched_cntl #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_load,
    output logic [31:0]      sbox_in,
    input  logic [31:0]      sbox_out,
    input  logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_out,
    output logic             busy,
    output logic             keys_ready
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t           state_q;
    logic [KEY_W-1:0] work_q;
    logic [KEY_W-1:0] rk_q [0:NUM_ROUNDS];
    logic [3:0]       round_q;
    logic [7:0]       rcon_q;
    logic [7:0]       rcon_d;
    logic [KEY_W-1:0] rk_out_q;
    logic             busy_q;
    logic             keys_ready_q;

    logic [31:0]      w3;
    logic [31:0]      t;
    logic [31:0]      n0, n1, n2, n3;
    logic [KEY_W-1:0] next_key_d;

    // Next round key derived from the working register and the shared S-box result.
    always_comb begin
        w3         = work_q[31:0];
        sbox_in    = {w3[23:0], w3[31:24]};
        t          = sbox_out ^ {rcon_q, 24'h0};
        n0         = work_q[127:96] ^ t;
        n1         = work_q[95:64]  ^ n0;
        n2         = work_q[63:32]  ^ n1;
        n3         = work_q[31:0]   ^ n2;
        next_key_d = {n0, n1, n2, n3};
        // xtime in GF(2^8): after 8'h80 the sequence continues 1b, 36.
        rcon_d     = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            work_q       <= '0;
            round_q      <= 4'd0;
            rcon_q       <= 8'h01;
            rk_out_q     <= '0;
            busy_q       <= 1'b0;
            keys_ready_q <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            // Read sees the pre-edge array, so a same-edge write returns the old value.
            rk_out_q <= (rk_idx <= LAST_ROUND) ? rk_q[rk_idx] : '0;

            if (key_load) begin
                // A new key always wins, aborting any run in progress.
                rk_q[0]      <= key_in;
                work_q       <= key_in;
                round_q      <= 4'd1;
                rcon_q       <= 8'h01;
                state_q      <= EXPAND;
                busy_q       <= 1'b1;
                keys_ready_q <= 1'b0;
            end else begin
                case (state_q)
                    EXPAND: begin
                        rk_q[round_q] <= next_key_d;
                        work_q        <= next_key_d;
                        rcon_q        <= rcon_d;
                        round_q       <= round_q + 4'd1;
                        if (round_q == LAST_ROUND) begin
                            state_q      <= READY;
                            busy_q       <= 1'b0;
                            keys_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        // IDLE and READY hold every key register.
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign rk_out     = rk_out_q;
    assign busy       = busy_q;
    assign keys_ready = keys_ready_q;

endmodule
